// File: rtl/divider_ctrl.sv
// ============================================================================
//  Module      : divider_ctrl
//  Description : Restoring unsigned divider sequencer driving a shared
//                subtract/restore ALU, one quotient bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Valid,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [31:0]      AluSrc1,
  output logic [31:0]      AluSrc2,
  output logic [5:0]       AluFunct,
  input  logic [31:0]      AluResult,
  input  logic             AluCarry
);

  localparam int         CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] C_FUNCT_SUB = 6'b001010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;

  logic [WIDTH:0]     w_s;
  logic [WIDTH-1:0]   w_q_next;
  logic [WIDTH-1:0]   w_r_next;
  logic               w_last;
  logic               w_unused;

  assign w_s      = {r_r, r_q[WIDTH-1]};
  assign w_r_next = AluCarry ? w_s[WIDTH-1:0] : AluResult[WIDTH-1:0];
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // Upper ALU result bits are always zero for a non-borrowing subtract.
  assign w_unused = ^AluResult[31:WIDTH];

  generate
    if (WIDTH == 1) begin : g_q_single
      assign w_q_next = ~AluCarry;
    end else begin : g_q_shift
      assign w_q_next = {r_q[WIDTH-2:0], ~AluCarry};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    Busy         = 1'b0;
    AluSrc1      = 32'd0;
    AluSrc2      = 32'd0;
    AluFunct     = 6'b000000;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_next = (Divisor != '0) ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        Busy     = 1'b1;
        AluSrc1  = 32'(r_d);
        AluSrc2  = 32'(w_s);
        AluFunct = C_FUNCT_SUB;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        Busy         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d       <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_divzero <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
    end else begin
      r_valid <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (Divisor != '0) begin
              r_d       <= Divisor;
              r_q       <= Dividend;
              r_r       <= '0;
              r_cnt     <= '0;
              r_divzero <= 1'b0;
            end else begin
              r_quot    <= '1;
              r_rem     <= Dividend;
              r_divzero <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Valid     = r_valid;
  assign DivZero   = r_divzero;
  assign Quotient  = r_quot;
  assign Remainder = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_divider_ctrl.sv
// ============================================================================
//  Module      : tb_divider_ctrl
//  Description : Scoreboard bench for divider_ctrl with a golden ALU model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Valid;
  logic             DivZero;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic [31:0]      AluSrc1;
  logic [31:0]      AluSrc2;
  logic [5:0]       AluFunct;
  logic [31:0]      AluResult;
  logic             AluCarry;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  divider_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Valid     (Valid),
    .DivZero   (DivZero),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .AluSrc1   (AluSrc1),
    .AluSrc2   (AluSrc2),
    .AluFunct  (AluFunct),
    .AluResult (AluResult),
    .AluCarry  (AluCarry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden ALU: subtract, or pass Src1 with borrow set.
  always_comb begin
    AluCarry  = 1'b0;
    AluResult = 32'd0;
    if (AluFunct == 6'b001010) begin
      AluCarry  = (AluSrc2 < AluSrc1);
      AluResult = AluCarry ? AluSrc1 : (AluSrc2 - AluSrc1);
    end
  end

  // Present a request at posedge+1; it is sampled on the following edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.dz = (b == '0);
    e.q  = e.dz ? {WIDTH{1'b1}} : a / b;
    e.r  = e.dz ? a : a % b;
    sb.push_back(e);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // Edges counted after the sampling edge until Valid is seen.
  task automatic wait_valid(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    while (Valid !== 1'b1 && cyc < 100) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({Busy, Valid, DivZero, Quotient, Remainder, AluSrc1, AluSrc2, AluFunct} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b valid=%b dz=%b q=%h r=%h funct=%h, expected all zero",
               Busy, Valid, DivZero, Quotient, Remainder, AluFunct);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit bok; exp_t e;
    n_cmp++;
    if ({AluFunct, AluSrc1, AluSrc2} !== '0) begin
      n_err++;
      $display("FAIL idle_alu: got funct=%h src1=%h src2=%h, expected zero", AluFunct, AluSrc1, AluSrc2);
    end
    issue(16'd100, 16'd7);
    n_cmp++;
    if (AluFunct !== 6'b001010 || AluSrc1 !== 32'd7 || AluSrc2 !== 32'd0) begin
      n_err++;
      $display("FAIL calc_alu: got funct=%h src1=%h src2=%h, expected 0a/7/0", AluFunct, AluSrc1, AluSrc2);
    end
    wait_valid(cyc, bok);
    e = sb.pop_front();
    n_cmp++;
    if (cyc !== WIDTH || !bok) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles busy_ok=%b, expected %0d busy_ok=1", cyc, bok, WIDTH);
    end
    n_cmp++;
    if ({Quotient, Remainder, DivZero} !== e) begin
      n_err++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, expected q=%0d r=%0d dz=%b",
               Quotient, Remainder, DivZero, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (Valid !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse: got valid=%b busy=%b, expected 0/0", Valid, Busy);
    end
  endtask

  task automatic test_patterns();
    logic [WIDTH-1:0] ta [5];
    logic [WIDTH-1:0] tb [5];
    int cyc; bit bok; exp_t e;
    ta = '{16'd5, 16'hFFFF, 16'hFFFF, 16'd0, 16'h8000};
    tb = '{16'd9, 16'd1,    16'hFFFF, 16'd3, 16'h00FF};
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i]);
      wait_valid(cyc, bok);
      e = sb.pop_front();
      n_cmp++;
      if ({Quotient, Remainder, DivZero} !== e || cyc !== WIDTH) begin
        n_err++;
        $display("FAIL pattern_%0d: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=%0d",
                 i, Quotient, Remainder, DivZero, cyc, e.q, e.r, e.dz, WIDTH);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit bok; exp_t e;
    issue(16'd1234, 16'd0);
    wait_valid(cyc, bok);
    e = sb.pop_front();
    n_cmp++;
    if ({Quotient, Remainder, DivZero} !== e || cyc !== 0) begin
      n_err++;
      $display("FAIL divzero_result: got q=%h r=%0d dz=%b lat=%0d, expected q=%h r=%0d dz=%b lat=0",
               Quotient, Remainder, DivZero, cyc, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (DivZero !== 1'b1 || Valid !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL divzero_hold: got dz=%b valid=%b busy=%b, expected 1/0/0", DivZero, Valid, Busy);
    end
    issue(16'd8, 16'd2);
    n_cmp++;
    if (DivZero !== 1'b0) begin
      n_err++;
      $display("FAIL divzero_clear: got dz=%b, expected 0", DivZero);
    end
    wait_valid(cyc, bok);
    e = sb.pop_front();
    n_cmp++;
    if ({Quotient, Remainder, DivZero} !== e) begin
      n_err++;
      $display("FAIL after_zero: got q=%0d r=%0d dz=%b, expected q=%0d r=%0d dz=%b",
               Quotient, Remainder, DivZero, e.q, e.r, e.dz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int cyc; bit bok; exp_t e;
    issue(16'd50, 16'd3);
    repeat (3) begin @(posedge clk); #1; end
    Start = 1'b1; Dividend = 16'd9; Divisor = 16'd9;
    repeat (4) begin @(posedge clk); #1; end
    Start = 1'b0;
    wait_valid(cyc, bok);
    e = sb.pop_front();
    n_cmp++;
    if ({Quotient, Remainder, DivZero} !== e || !bok) begin
      n_err++;
      $display("FAIL ignore_start: got q=%0d r=%0d dz=%b busy_ok=%b, expected q=%0d r=%0d dz=%b",
               Quotient, Remainder, DivZero, bok, e.q, e.r, e.dz);
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (Valid !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_rerun: got valid=%b busy=%b, expected 0/0", Valid, Busy);
    end
  endtask

  task automatic test_async_reset();
    int cyc; bit bok; bit saw_valid; exp_t e;
    issue(16'd1000, 16'd7);
    repeat (8) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({Busy, Valid, DivZero, Quotient, Remainder, AluSrc1, AluSrc2, AluFunct} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b valid=%b q=%h r=%h funct=%h, expected all zero",
               Busy, Valid, Quotient, Remainder, AluFunct);
    end
    sb.delete();
    saw_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (Valid === 1'b1) saw_valid = 1'b1; end
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (Valid === 1'b1) saw_valid = 1'b1; end
    n_cmp++;
    if (saw_valid) begin
      n_err++;
      $display("FAIL abandoned_valid: got valid pulse, expected none");
    end
    issue(16'd10, 16'd3);
    wait_valid(cyc, bok);
    e = sb.pop_front();
    n_cmp++;
    if ({Quotient, Remainder, DivZero} !== e || cyc !== WIDTH) begin
      n_err++;
      $display("FAIL post_reset: got q=%0d r=%0d dz=%b lat=%0d, expected q=%0d r=%0d dz=%b lat=%0d",
               Quotient, Remainder, DivZero, cyc, e.q, e.r, e.dz, WIDTH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok; exp_t e;
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'($urandom);
      b = (i == 3) ? '0 : WIDTH'($urandom_range(1, 16'hFFFF) >> (i * 2));
      issue(a, b);
      wait_valid(cyc, bok);
      e = sb.pop_front();
      n_cmp++;
      if ({Quotient, Remainder, DivZero} !== e || cyc !== (e.dz ? 0 : WIDTH)) begin
        n_err++;
        $display("FAIL b2b_%0d (%h/%h): got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b",
                 i, a, b, Quotient, Remainder, DivZero, cyc, e.q, e.r, e.dz);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
